mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequencing controller plus shift-add datapath for the micro-multiplier tile. It accepts two unsigned operands over a narrow valid/ready byte stream and runs a WIDTH-cycle shift-add multiplication. It returns the 2·WIDTH-bit product as two WIDTH-bit beats, low beat first. It sits between the tile pin mux (dedicated inputs / outputs) and the top-level wrapper, so the 8-bit pins can carry a full 16-bit result.

## Interface
- WIDTH, default 8: operand width; product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  tile enable; low freezes all state.
- in_valid  in  1  operand beat present on in_data.
- in_ready  out  1  controller accepts an operand beat this cycle.
- in_data  in  WIDTH  operand beat; first beat = A (multiplicand), second = B (multiplier).
- out_valid  out  1  product beat present on out_data.
- out_ready  in  1  consumer accepts the product beat.
- out_data  out  WIDTH  product beat; low half first, then high half.
- busy  out  1  an operation is in progress (A accepted, high beat not yet taken).

## Operation
- States: LOAD_A, LOAD_B, CALC, OUT_LO, OUT_HI. Moore-decoded: in_ready = ena & (LOAD_A | LOAD_B); out_valid = ena & (OUT_LO | OUT_HI); busy = state != LOAD_A.
- Transfer occurs at a rising edge with valid & ready both high. Valid and ready are never combinationally dependent on each other.
- LOAD_A: on transfer, mcand <= in_data, go LOAD_B.
- LOAD_B: on transfer, mplier <= in_data, acc <= 0, cnt <= 0, go CALC.
- CALC, one iteration per cycle:
  - sum = {1'b0,acc} + (mplier[0] ? mcand : 0), WIDTH+1 bits.
  - {acc, mplier} <= {sum, mplier} >> 1.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1, go OUT_LO. cnt is a $clog2(WIDTH)+1-bit counter.
- Result: product = {acc, mplier}, exact, no truncation. Max is (2^WIDTH-1)^2, which fits in 2·WIDTH bits.
- OUT_LO: out_data = mplier (low half); on transfer go OUT_HI.
- OUT_HI: out_data = acc (high half); on transfer go LOAD_A.
- In LOAD_A/LOAD_B/CALC, out_data = acc, i.e. the high half of the last product (0 after reset). It is don't-care to consumers but deterministic.
- in_valid outside LOAD_A/LOAD_B is ignored. out_ready outside OUT_LO/OUT_HI is ignored.
- ena low: no register updates, no transfers, in_ready = out_valid = 0. busy still reflects state. When ena returns high, operation resumes exactly where it stopped.
- Reset (async, any state, including mid-CALC or mid-output):
  - state = LOAD_A; mcand, mplier, acc, cnt = 0.
  - in_ready = ena, out_valid = 0, out_data = 0, busy = 0.
  - The partial operation is discarded; no beat is emitted.

## Timing
- Operand accept: 1 cycle per beat. Back-to-back A then B is possible on consecutive edges.
- B accepted at edge k (ena high throughout): CALC occupies edges k+1..k+WIDTH. out_valid rises after edge k+WIDTH. For WIDTH=8, this is 8 cycles after the B handshake.
- Each cycle with ena low stretches the latency by exactly one cycle.
- Output: low beat held stable (out_valid=1, out_data constant) until accepted. High beat appears the cycle after low-beat transfer.
- After high-beat transfer at edge m, in_ready is high in cycle m+1. Minimum issue interval with no stalls = 2 + WIDTH + 2 cycles (12 for WIDTH=8).
- No combinational path from in_valid/out_ready to any output.

## Test plan
- Basic multiply: A=13, B=11, out_ready=1 → out_valid rises 8 cycles after the B handshake; beats 0x8F then 0x00; busy drops after the high beat.
- Max operands: A=0xFF, B=0xFF → beats 0x01 then 0xFE (65025). Back-to-back op A=0x00, B=0xC8 → 0x00, 0x00. Then A=0xC8, B=0x01 → 0xC8, 0x00.
- Backpressure: A=0xC8, B=0x01, out_ready=0 for 5 cycles in OUT_LO → out_valid=1 and out_data=0xC8 stable all 5 cycles; in_ready=0. Extra in_valid pulses during CALC and OUT_* are ignored; the next op (3×5) still yields 0x0F, 0x00.
- Enable stall: A=7, B=9, ena low for 3 cycles mid-CALC → in_ready/out_valid stay 0 during the stall; latency is 11 cycles from B; beats 0x3F, 0x00.
- Reset mid-operation: assert rst asynchronously (between edges) in the 4th CALC cycle → busy=0, out_valid=0, out_data=0, state LOAD_A immediately with no clock. After release, A=7, B=6 → 0x2A, 0x00.
- Reset during OUT_HI: rst while the high beat is pending → no high beat emitted. The next op 0x10×0x10 → 0x00, 0x01.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequencing controller and shift-add datapath for the micro-multiplier tile.
// It takes two unsigned WIDTH-bit operands as two beats over a valid/ready
// stream: A (the multiplicand) first, then B (the multiplier). It spends WIDTH
// cycles on a shift-add multiplication. It then returns the 2*WIDTH-bit product
// as two WIDTH-bit beats, low half first, so narrow pins can carry the full result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   ena        tile enable; low freezes all state and blocks all transfers
//   in_valid   operand beat present on in_data
//   in_ready   operand beat accepted this cycle (LOAD_A / LOAD_B only)
//   in_data    operand beat: A first, then B
//   out_valid  product beat present on out_data (OUT_LO / OUT_HI only)
//   out_ready  consumer accepts the product beat
//   out_data   product beat: low half, then high half
//   busy       operation in progress (A accepted, high beat not yet taken)
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        CALC   = 3'd2,
        OUT_LO = 3'd3,
        OUT_HI = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last_iter;
    logic [WIDTH:0]     w_sum;

    // Handshakes use only registered (Moore) ready/valid, so neither side
    // ever sees a combinational path from its own valid/ready.
    assign w_in_xfer   = in_valid  & in_ready;
    assign w_out_xfer  = out_valid & out_ready;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // One partial product per cycle; the extra top bit keeps the carry so
    // the shifted {acc, mplier} stays exact.
    assign w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else if (ena) begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        out_data     = r_acc;
        case (r_state)
            LOAD_A: begin
                in_ready = ena;
                busy     = 1'b0;
                if (w_in_xfer) w_next_state = LOAD_B;
            end
            LOAD_B: begin
                in_ready = ena;
                if (w_in_xfer) w_next_state = CALC;
            end
            CALC: begin
                if (w_last_iter) w_next_state = OUT_LO;
            end
            OUT_LO: begin
                out_valid = ena;
                out_data  = r_mplier;
                if (w_out_xfer) w_next_state = OUT_HI;
            end
            OUT_HI: begin
                out_valid = ena;
                if (w_out_xfer) w_next_state = LOAD_A;
            end
            default: begin
                w_next_state = LOAD_A;
                busy         = 1'b0;
            end
        endcase
    end

    // Operand capture and shift-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (ena) begin
            case (r_state)
                LOAD_A: begin
                    if (w_in_xfer) r_mcand <= in_data;
                end
                LOAD_B: begin
                    if (w_in_xfer) begin
                        r_mplier <= in_data;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    // {acc, mplier} <= {sum, mplier} >> 1
                    r_acc    <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        int i;
        in_data  = d;
        in_valid = 1'b1;
        i = 0;
        while (!in_ready && i < 40) begin
            step();
            i++;
        end
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd1);
    endtask

    task automatic take_beats(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        out_ready = 1'b1;
        chk({tag, "_lo"}, {8'd0, out_data}, {8'd0, lo});
        step();
        chk({tag, "_hi_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_hi"}, {8'd0, out_data}, {8'd0, hi});
        step();
        out_ready = 1'b0;
        chk({tag, "_busy_after"}, {15'd0, busy}, 16'd0);
        chk({tag, "_in_ready_after"}, {15'd0, in_ready}, 16'd1);
    endtask

    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] lo, input logic [7:0] hi);
        int n;
        send({tag, "_A"}, a);
        send({tag, "_B"}, b);
        wait_out(tag, n);
        take_beats(tag, lo, hi);
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data",  {8'd0, out_data},   16'd0);
        chk("rst_busy",      {15'd0, busy},      16'd0);
        rst = 1'b0;
        step();

        // Basic multiply 13 x 11 = 143, latency 8 from B
        send("basic_A", 8'd13);
        chk("basic_busy_after_A", {15'd0, busy}, 16'd1);
        send("basic_B", 8'd11);
        wait_out("basic", lat);
        chk("basic_latency", 16'(lat), 16'd8);
        chk("basic_busy_out", {15'd0, busy}, 16'd1);
        chk("basic_in_ready_out", {15'd0, in_ready}, 16'd0);
        take_beats("basic", 8'h8F, 8'h00);

        // Max operands and back-to-back ops
        op("max", 8'hFF, 8'hFF, 8'h01, 8'hFE);
        op("zeroA", 8'h00, 8'hC8, 8'h00, 8'h00);
        op("c8x1", 8'hC8, 8'h01, 8'hC8, 8'h00);

        // Backpressure with stray in_valid pulses during CALC and OUT_LO
        send("bp_A", 8'hC8);
        send("bp_B", 8'h01);
        in_valid = 1'b1;
        in_data  = 8'h55;
        wait_out("bp", lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_hold_data",  {8'd0, out_data},   16'h00C8);
            chk("bp_hold_in_ready", {15'd0, in_ready}, 16'd0);
            step();
        end
        in_valid = 1'b0;
        take_beats("bp", 8'hC8, 8'h00);
        op("bp_next", 8'd3, 8'd5, 8'h0F, 8'h00);

        // Enable stall of 3 cycles mid-CALC: 7 x 9 = 63, latency 11
        send("stall_A", 8'd7);
        send("stall_B", 8'd9);
        step();
        step();
        step();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready",  {15'd0, in_ready},  16'd0);
            chk("stall_out_valid", {15'd0, out_valid}, 16'd0);
            chk("stall_busy",      {15'd0, busy},      16'd1);
            step();
        end
        ena = 1'b1;
        wait_out("stall", lat);
        chk("stall_latency", 16'(lat + 6), 16'd11);
        take_beats("stall", 8'h3F, 8'h00);

        // Asynchronous reset in the 4th CALC cycle
        send("rcalc_A", 8'hFF);
        send("rcalc_B", 8'hFF);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rcalc_busy",      {15'd0, busy},      16'd0);
        chk("rcalc_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rcalc_out_data",  {8'd0, out_data},   16'd0);
        chk("rcalc_in_ready",  {15'd0, in_ready},  16'd1);
        step();
        rst = 1'b0;
        op("rcalc_next", 8'd7, 8'd6, 8'h2A, 8'h00);

        // Asynchronous reset while the high beat is pending: 0x20 x 0x10 = 0x0200
        send("rhi_A", 8'h20);
        send("rhi_B", 8'h10);
        wait_out("rhi", lat);
        out_ready = 1'b1;
        chk("rhi_lo", {8'd0, out_data}, 16'h0000);
        step();
        out_ready = 1'b0;
        chk("rhi_hi_pending", {8'd0, out_data}, 16'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("rhi_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rhi_out_data",  {8'd0, out_data},   16'd0);
        chk("rhi_busy",      {15'd0, busy},      16'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rhi_no_beat", {15'd0, out_valid}, 16'd0);
        step();
        chk("rhi_no_beat2", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;
        op("rhi_next", 8'h10, 8'h10, 8'h00, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
